// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan sequencer.
//   state_t : sequencer state (IDLE, DWELL)
//   NUM_CH  : number of selectable channels
//   SEL_W   : width of a channel index
package scan_seq_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      DWELL = 1'b1
   } state_t;

endpackage

// File: rtl/mask_priority_picker.sv
// Combinational channel picker.
//   mask       : channel enables
//   cur        : current channel index
//   from_start : 1 = ignore cur and return the lowest enabled channel
//   next_idx   : lowest enabled index strictly above cur (or overall)
//   found      : next_idx is meaningful
module mask_priority_picker
   import scan_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              from_start,
   output logic [SEL_W-1:0]  next_idx,
   output logic              found
);

   logic [NUM_CH-1:0] eligible;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
         assign eligible[gi] = mask[gi] && (from_start || (SEL_W'(gi) > cur));
      end
   endgenerate

   // Walk from the top down so the lowest eligible index wins.
   always_comb begin
      next_idx = '0;
      found    = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            next_idx = SEL_W'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/scan_sequencer_3bit.sv
// Channel scanner driving the select lines of a 3-to-8 decoder.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a scan when idle
//   stop       : abort; wins over start
//   continuous : at pass end, 1 = wrap, 0 = finish
//   chan_mask  : channel enables, latched at each pass boundary
//   dwell      : hold time is dwell+1 cycles, latched at each pass boundary
//   sel        : channel index (0 while idle)
//   sel_valid  : sel is an active channel
//   scan_done  : pulse on the last cycle of a completed pass (or empty start)
//   busy       : high while scanning
module scan_sequencer_3bit
   import scan_seq_pkg::*;
#(
   parameter int DWELL_W = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [7:0]         chan_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2:0]         sel,
   output logic               sel_valid,
   output logic               scan_done,
   output logic               busy
);

   state_t             state_reg, state_next;
   logic [NUM_CH-1:0]  mask_q_reg, mask_q_next;
   logic [DWELL_W-1:0] dwell_q_reg, dwell_q_next;
   logic [DWELL_W-1:0] cnt_reg, cnt_next;
   logic [SEL_W-1:0]   cur_reg, cur_next;
   logic               empty_done_reg, empty_done_next;

   logic [SEL_W-1:0]   adv_idx, first_idx;
   logic               adv_found, first_found;
   logic               last_cycle, pass_end;

   // Next channel within the latched mask.
   mask_priority_picker u_adv (
      .mask       (mask_q_reg),
      .cur        (cur_reg),
      .from_start (1'b0),
      .next_idx   (adv_idx),
      .found      (adv_found)
   );

   // First channel of a fresh pass, taken from the live mask input.
   mask_priority_picker u_first (
      .mask       (chan_mask),
      .cur        ('0),
      .from_start (1'b1),
      .next_idx   (first_idx),
      .found      (first_found)
   );

   assign last_cycle = (state_reg == DWELL) && (cnt_reg == dwell_q_reg);
   assign pass_end   = last_cycle && !adv_found;

   // cur is held at 0 whenever idle, so it can drive sel directly.
   assign sel       = cur_reg;
   assign sel_valid = (state_reg == DWELL);
   assign busy      = (state_reg == DWELL);
   // An abort in the same cycle retracts the completion pulse.
   assign scan_done = (pass_end || empty_done_reg) && !stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         mask_q_reg     <= '0;
         dwell_q_reg    <= '0;
         cnt_reg        <= '0;
         cur_reg        <= '0;
         empty_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mask_q_reg     <= mask_q_next;
         dwell_q_reg    <= dwell_q_next;
         cnt_reg        <= cnt_next;
         cur_reg        <= cur_next;
         empty_done_reg <= empty_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      mask_q_next     = mask_q_reg;
      dwell_q_next    = dwell_q_reg;
      cnt_next        = cnt_reg;
      cur_next        = cur_reg;
      empty_done_next = 1'b0;

      if (stop) begin
         state_next = IDLE;
         cnt_next   = '0;
         cur_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (first_found) begin
                     mask_q_next  = chan_mask;
                     dwell_q_next = dwell;
                     cur_next     = first_idx;
                     cnt_next     = '0;
                     state_next   = DWELL;
                  end else begin
                     empty_done_next = 1'b1;
                  end
               end
            end
            DWELL: begin
               if (!last_cycle) begin
                  cnt_next = cnt_reg + DWELL_W'(1);
               end else if (adv_found) begin
                  cur_next = adv_idx;
                  cnt_next = '0;
               end else if (continuous) begin
                  // Wrap: pick up the current mask/dwell for the next pass.
                  mask_q_next  = chan_mask;
                  dwell_q_next = dwell;
                  cnt_next     = '0;
                  if (first_found) begin
                     cur_next = first_idx;
                  end else begin
                     cur_next   = '0;
                     state_next = IDLE;
                  end
               end else begin
                  cnt_next   = '0;
                  cur_next   = '0;
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               cur_next   = '0;
            end
         endcase
      end
   end

endmodule
